// File: rtl/pipe_stall_ctrl.sv
// Hazard, stall and exception-sequencing controller for the five-stage pipeline.
// Decides per cycle between exception flush, eret return, and RAW/HI-LO stalls.
module pipe_stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] wreg_e,
  input  logic [1:0] tnew_e,
  input  logic [4:0] wreg_m,
  input  logic [1:0] tnew_m,
  input  logic       md_d,
  input  logic       md_start_e,
  input  logic       md_div_e,
  input  logic       exc_m,
  input  logic       eret_d,
  output logic       stall,
  output logic       flush_e,
  output logic       flush_all,
  output logic       pc_sel_exc,
  output logic       pc_sel_epc,
  output logic       md_busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXL  = 1'b1;

  logic [0:0] state, state_nxt;
  logic [3:0] md_cnt;
  logic       rs_haz, rt_haz, md_haz, raw_stall, exc_acc;

  // Register $0 never creates a dependency; tuse = 3 can never be exceeded by a 2-bit tnew.
  assign rs_haz = (rs_d != 5'd0) &&
                  (((rs_d == wreg_e) && (tnew_e > tuse_rs_d)) ||
                   ((rs_d == wreg_m) && (tnew_m > tuse_rs_d)));
  assign rt_haz = (rt_d != 5'd0) &&
                  (((rt_d == wreg_e) && (tnew_e > tuse_rt_d)) ||
                   ((rt_d == wreg_m) && (tnew_m > tuse_rt_d)));

  assign md_busy   = (md_cnt != 4'd0);
  assign md_haz    = md_d && (md_busy || md_start_e);
  assign raw_stall = rs_haz || rt_haz || md_haz;
  assign exc_acc   = exc_m && (state == ST_IDLE);

  // NOTE: every output gets a default first so no path through the priority chain infers a latch.
  always_comb begin
    stall      = 1'b0;
    flush_e    = 1'b0;
    flush_all  = 1'b0;
    pc_sel_exc = 1'b0;
    pc_sel_epc = 1'b0;
    state_nxt  = state;
    if (exc_acc) begin
      flush_all  = 1'b1;
      pc_sel_exc = 1'b1;
      state_nxt  = ST_EXL;
    end else if (eret_d && !raw_stall) begin
      pc_sel_epc = 1'b1;
      state_nxt  = ST_IDLE;
    end else begin
      stall   = raw_stall;
      flush_e = raw_stall;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A start squashed by an accepted exception belongs to a younger instruction and must not load.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= 4'd0;
    end else if (md_start_e && !exc_acc) begin
      md_cnt <= md_div_e ? 4'(DIV_CYC) : 4'(MULT_CYC);
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model (exception flag, busy cycles left).
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, wreg_e, wreg_m;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic       md_d, md_start_e, md_div_e, exc_m, eret_d;
  logic       stall, flush_e, flush_all, pc_sel_exc, pc_sel_epc, md_busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: whether an exception is being serviced, and busy cycles remaining.
  bit m_known = 0;
  bit m_exl;
  int m_left;
  bit e_stall, e_flush_e, e_flush_all, e_exc, e_epc, e_busy;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .wreg_e(wreg_e), .tnew_e(tnew_e), .wreg_m(wreg_m), .tnew_m(tnew_m),
    .md_d(md_d), .md_start_e(md_start_e), .md_div_e(md_div_e),
    .exc_m(exc_m), .eret_d(eret_d),
    .stall(stall), .flush_e(flush_e), .flush_all(flush_all),
    .pc_sel_exc(pc_sel_exc), .pc_sel_epc(pc_sel_epc), .md_busy(md_busy)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic bit depends(input int src, input int tuse);
    int ready_e, ready_m;
    if (src == 0) return 0;
    // Operand is late if the producer's result arrives after the consumer needs it.
    ready_e = (src == wreg_e) ? int'(tnew_e) : 0;
    ready_m = (src == wreg_m) ? int'(tnew_m) : 0;
    return (ready_e > tuse) || (ready_m > tuse);
  endfunction

  task automatic model_outputs();
    bit raw, exc;
    raw = depends(rs_d, tuse_rs_d) || depends(rt_d, tuse_rt_d) ||
          (md_d && (m_left > 0 || md_start_e));
    exc = exc_m && !m_exl;
    e_busy      = (m_left > 0);
    e_flush_all = exc;
    e_exc       = exc;
    e_epc       = !exc && eret_d && !raw;
    e_stall     = !exc && !e_epc && raw;
    e_flush_e   = e_stall;
  endtask

  task automatic model_edge();
    bit exc;
    exc = exc_m && !m_exl;
    if (reset) begin
      m_exl = 0; m_left = 0; m_known = 1;
    end else begin
      if (exc) m_exl = 1;
      else if (e_epc) m_exl = 0;
      if (md_start_e && !exc) m_left = md_div_e ? 10 : 5;
      else if (m_left > 0) m_left--;
    end
  endtask

  // Compare all outputs before the edge; explicit directed checks may follow before tick().
  task automatic settle();
    #2;
    model_outputs();
    if (m_known) begin
      check("stall", stall, e_stall);
      check("flush_e", flush_e, e_flush_e);
      check("flush_all", flush_all, e_flush_all);
      check("pc_sel_exc", pc_sel_exc, e_exc);
      check("pc_sel_epc", pc_sel_epc, e_epc);
      check("md_busy", md_busy, e_busy);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic idle_inputs();
    reset = 0; rs_d = 0; rt_d = 0; tuse_rs_d = 3; tuse_rt_d = 3;
    wreg_e = 0; tnew_e = 0; wreg_m = 0; tnew_m = 0;
    md_d = 0; md_start_e = 0; md_div_e = 0; exc_m = 0; eret_d = 0;
  endtask

  initial begin
    int n;
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    step();
    step();
    reset = 0;
    settle();
    check("reset_all_zero", stall | flush_e | flush_all | pc_sel_exc | pc_sel_epc | md_busy, 1'b0);
    tick();

    // Load-use on rs, then the producer moves to M with one cycle left.
    rs_d = 2; tuse_rs_d = 1; wreg_e = 2; tnew_e = 2;
    settle(); check("load_use_stall", stall, 1'b1); check("load_use_flush_e", flush_e, 1'b1); tick();
    wreg_e = 0; tnew_e = 0; wreg_m = 2; tnew_m = 1;
    settle(); check("load_use_clear", stall, 1'b0); tick();

    // $0 exemption and unused operand.
    idle_inputs(); rs_d = 0; wreg_e = 0; tnew_e = 2; tuse_rs_d = 0;
    settle(); check("zero_reg_exempt", stall, 1'b0); tick();
    rs_d = 5; wreg_e = 5; tnew_e = 2; tuse_rs_d = 3;
    settle(); check("tuse3_exempt", stall, 1'b0); tick();
    idle_inputs(); rt_d = 7; tuse_rt_d = 0; wreg_m = 7; tnew_m = 1;
    settle(); check("rt_hazard_m", stall, 1'b1); tick();

    // Div then mult busy windows with an HI/LO consumer waiting in D.
    for (int op = 0; op < 2; op++) begin
      idle_inputs(); md_start_e = 1; md_div_e = (op == 0);
      step();
      idle_inputs(); md_d = 1; n = 0;
      for (int c = 0; c < 13; c++) begin
        settle(); if (stall) n++; tick();
      end
      check(op == 0 ? "div_window_len" : "mult_window_len", n == (op == 0 ? 10 : 5), 1'b1);
    end

    // Exception beats a pending stall and squashes a concurrent start.
    idle_inputs(); exc_m = 1; rs_d = 3; wreg_e = 3; tnew_e = 2; tuse_rs_d = 0;
    md_start_e = 1; md_div_e = 1;
    settle(); check("exc_flush_all", flush_all, 1'b1); check("exc_pc", pc_sel_exc, 1'b1);
    check("exc_no_stall", stall, 1'b0); tick();
    idle_inputs(); exc_m = 1;
    settle(); check("nested_masked", flush_all | pc_sel_exc | md_busy, 1'b0); tick();

    // Eret waits for the hazard, then returns to IDLE where exceptions are taken again.
    idle_inputs(); eret_d = 1; rs_d = 4; wreg_e = 4; tnew_e = 1; tuse_rs_d = 0;
    settle(); check("eret_held_epc", pc_sel_epc, 1'b0); check("eret_held_stall", stall, 1'b1); tick();
    idle_inputs(); eret_d = 1;
    settle(); check("eret_go", pc_sel_epc, 1'b1); tick();
    idle_inputs(); exc_m = 1;
    settle(); check("exc_after_eret", pc_sel_exc, 1'b1); tick();

    // Reset three cycles into a div clears both the window and EXL.
    idle_inputs(); md_start_e = 1; md_div_e = 1; step();
    idle_inputs(); step(); step(); step();
    reset = 1; step();
    reset = 0;
    settle(); check("reset_mid_div_busy", md_busy, 1'b0); tick();
    exc_m = 1;
    settle(); check("reset_mid_div_idle", pc_sel_exc, 1'b1); tick();

    // Random traffic on a narrow register range so hazards are frequent.
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 59) == 0);
      rs_d       = 5'($urandom_range(0, 3));
      rt_d       = 5'($urandom_range(0, 3));
      tuse_rs_d  = 2'($urandom);
      tuse_rt_d  = 2'($urandom);
      wreg_e     = 5'($urandom_range(0, 3));
      wreg_m     = 5'($urandom_range(0, 3));
      tnew_e     = 2'($urandom);
      tnew_m     = 2'($urandom);
      md_d       = ($urandom_range(0, 3) == 0);
      md_start_e = ($urandom_range(0, 9) == 0);
      md_div_e   = 1'($urandom);
      exc_m      = ($urandom_range(0, 7) == 0);
      eret_d     = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
